mem_port_arbiter: RTL

Two-requester arbiter for the single-port 16-bit synchronous data memory (`memory`, port `en`/`rd_en`/`wr_en`/`addr`/`din`/`dout`). It lets the `cpu` and a second master (boot loader / DMA) share the memory instead of the CPU owning it exclusively. It sits between both masters and the memory, issuing at most one access per cycle. Arbitration is round-robin with bounded burst locking, and read data is returned with a per-requester valid.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_rd_pipe.sv | 32 +++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory port arbiter.
// States, requester ids and the legal read-latency range live here.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } req_id_e;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int RD_LAT_MIN     = 1;
  localparam int RD_LAT_MAX     = 3;

  function automatic req_id_e other_id(input req_id_e id);
    return (id == M0) ? M1 : M0;
  endfunction

endpackage

// File: rtl/mem_arb_rd_pipe.sv
// Read-return tag pipeline: a {valid, id} beat pushed at accept emerges RD_LATENCY+1 cycles later.
// No backpressure; one tag per cycle, returned strictly in issue order.
module mem_arb_rd_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push_vld,
  input  req_id_e push_id,
  output logic    m0_rvalid,
  output logic    m1_rvalid
);

  logic [RD_LATENCY:0] vld_q;
  logic [RD_LATENCY:0] id_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q <= {vld_q[RD_LATENCY-1:0], push_vld};
      id_q  <= {id_q[RD_LATENCY-1:0], push_id};
    end
  end

  assign m0_rvalid = vld_q[RD_LATENCY] & ~id_q[RD_LATENCY];
  assign m1_rvalid = vld_q[RD_LATENCY] &  id_q[RD_LATENCY];

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter with bounded burst locking sharing one synchronous memory between two masters.
// Grant is combinational; memory command issues one cycle after accept; read data returns RD_LATENCY later.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RD_LATENCY = 1,
  parameter int MAX_LOCK   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  m0_req_i,
  input  logic                  m0_we_i,
  input  logic                  m0_lock_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic                  m1_lock_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic                  m0_gnt_o,
  output logic                  m1_gnt_o,
  output logic                  m0_rvalid_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  mem_en_o,
  output logic                  mem_rd_en_o,
  output logic                  mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_din_o,
  input  logic [DATA_WIDTH-1:0] mem_dout_i
);

  if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_rd_latency
    $error("mem_port_arbiter: RD_LATENCY out of range");
  end
  if (MAX_LOCK < 2 || MAX_LOCK > 255) begin : g_bad_max_lock
    $error("mem_port_arbiter: MAX_LOCK out of range");
  end

  localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

  arb_state_e            state_q, state_d;
  req_id_e               rr_ptr_q, rr_ptr_d;
  logic [7:0]            lock_cnt_q, lock_cnt_d;
  logic                  gnt0, gnt1, gnt_any, gnt_we, gnt_lock;
  req_id_e               gnt_id;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0] gnt_wdata;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_cnt_d = lock_cnt_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_req_i && m1_req_i) begin
          gnt0 = (rr_ptr_q == M0);
          gnt1 = (rr_ptr_q == M1);
        end else begin
          gnt0 = m0_req_i;
          gnt1 = m1_req_i;
        end
      end
      LOCK0:   gnt0 = m0_req_i;
      LOCK1:   gnt1 = m1_req_i;
      default: ;
    endcase

    gnt_any   = gnt0 | gnt1;
    gnt_id    = gnt1 ? M1 : M0;
    gnt_we    = gnt1 ? m1_we_i    : m0_we_i;
    gnt_lock  = gnt1 ? m1_lock_i  : m0_lock_i;
    gnt_addr  = gnt1 ? m1_addr_i  : m0_addr_i;
    gnt_wdata = gnt1 ? m1_wdata_i : m0_wdata_i;

    if (state_q == IDLE) begin
      if (gnt_any) begin
        rr_ptr_d = other_id(gnt_id);
        if (gnt_lock) begin
          state_d    = gnt1 ? LOCK1 : LOCK0;
          lock_cnt_d = 8'd1;
        end
      end
    end else if (!gnt_any) begin
      // Lock owner walked away: release without granting this cycle.
      state_d    = IDLE;
      lock_cnt_d = 8'd0;
    end else if (!gnt_lock || lock_cnt_q == MAX_LOCK_C - 8'd1) begin
      state_d    = IDLE;
      lock_cnt_d = 8'd0;
      rr_ptr_d   = other_id(gnt_id);
    end else begin
      lock_cnt_d = lock_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_ptr_q   <= M0;
      lock_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Address/data hold their last value on idle cycles; din only moves on writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_en_o    <= 1'b0;
      mem_rd_en_o <= 1'b0;
      mem_wr_en_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_din_o   <= '0;
    end else begin
      mem_en_o    <= gnt_any;
      mem_rd_en_o <= gnt_any & ~gnt_we;
      mem_wr_en_o <= gnt_any &  gnt_we;
      if (gnt_any) begin
        mem_addr_o <= gnt_addr;
      end
      if (gnt_any && gnt_we) begin
        mem_din_o <= gnt_wdata;
      end
    end
  end

  mem_arb_rd_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_rd_pipe (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push_vld (gnt_any & ~gnt_we),
    .push_id  (gnt_id),
    .m0_rvalid(m0_rvalid_o),
    .m1_rvalid(m1_rvalid_o)
  );

  // Grants and pass-through data are forced low while reset is held.
  assign m0_gnt_o   = gnt0 & rst_ni;
  assign m1_gnt_o   = gnt1 & rst_ni;
  assign m0_rdata_o = rst_ni ? mem_dout_i : '0;
  assign m1_rdata_o = rst_ni ? mem_dout_i : '0;

endmodule
